// File: rtl/skewed_row_dispatcher.sv
// rtl/skewed_row_dispatcher.sv - steers element addresses into per-row queues, captures SRAM lanes,
// and releases rows to the array with an optional one-cycle-per-row skew.
module skewed_row_dispatcher #(
  parameter int ROUTER_COUNT    = 4,
  parameter int SRAM_DATA_WIDTH = 64,
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 11,
  parameter int ADDR_DEPTH      = 16,
  parameter int DATA_DEPTH      = 16,
  localparam int LANES     = SRAM_DATA_WIDTH / DATA_WIDTH,
  localparam int LANE_BITS = $clog2(LANES),
  localparam int WORD_W    = ADDR_WIDTH - LANE_BITS,
  localparam int RID_W     = $clog2(ROUTER_COUNT)
) (
  input  logic                                 i_clk,
  input  logic                                 i_nrst,
  input  logic                                 i_reg_clear,
  input  logic                                 i_skew_en,
  input  logic                                 i_ag_valid,
  input  logic [RID_W-1:0]                     i_row_id,
  input  logic [ADDR_WIDTH-1:0]                i_ag_addr,
  output logic                                 o_ag_ready,
  input  logic                                 i_data_valid,
  input  logic [WORD_W-1:0]                    i_addr,
  input  logic [SRAM_DATA_WIDTH-1:0]           i_data,
  input  logic                                 i_pop_en,
  output logic [ROUTER_COUNT*DATA_WIDTH-1:0]   o_data,
  output logic [ROUTER_COUNT-1:0]              o_data_valid,
  output logic                                 o_addr_empty,
  output logic                                 o_data_empty,
  output logic                                 o_overflow
);

  localparam int SK_W = RID_W + 1;
  localparam int AP_W = $clog2(ADDR_DEPTH);
  localparam int DP_W = $clog2(DATA_DEPTH);

  logic [ROUTER_COUNT-1:0] w_a_empty, w_a_full, w_d_empty, w_drop;
  logic [SK_W-1:0]         r_skew;
  logic                    r_overflow;

  // Row ids beyond ROUTER_COUNT match no row and so read as not ready.
  always_comb begin
    o_ag_ready = 1'b0;
    for (int r = 0; r < ROUTER_COUNT; r++)
      if (i_row_id == RID_W'(r)) o_ag_ready = ~w_a_full[r];
  end

  for (genvar g = 0; g < ROUTER_COUNT; g++) begin : g_row
    logic [ADDR_WIDTH-1:0] r_amem [ADDR_DEPTH];
    logic [DATA_WIDTH-1:0] r_dmem [DATA_DEPTH];
    logic [AP_W:0]         r_awp, r_arp;
    logic [DP_W:0]         r_dwp, r_drp;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_vld;
    logic [ADDR_WIDTH-1:0] w_ahead;
    logic [LANE_BITS-1:0]  w_lane;
    logic                  w_apush, w_match, w_d_full, w_dpush, w_en, w_pop;

    assign w_a_empty[g] = (r_awp == r_arp);
    assign w_a_full[g]  = (r_awp == {~r_arp[AP_W], r_arp[AP_W-1:0]});
    assign w_d_empty[g] = (r_dwp == r_drp);
    assign w_d_full     = (r_dwp == {~r_drp[DP_W], r_drp[DP_W-1:0]});
    assign w_ahead      = r_amem[r_arp[AP_W-1:0]];
    assign w_lane       = w_ahead[LANE_BITS-1:0];
    assign w_apush      = i_ag_valid & (i_row_id == RID_W'(g)) & ~w_a_full[g];
    assign w_match      = i_data_valid & ~w_a_empty[g] & (w_ahead[ADDR_WIDTH-1:LANE_BITS] == i_addr);

    // Row 0 leads the skew, so it is never held back.
    if (g == 0) begin : g_lead
      assign w_en = 1'b1;
    end else begin : g_skewed
      assign w_en = ~i_skew_en | (r_skew >= SK_W'(g));
    end

    assign w_pop     = i_pop_en & w_en & ~w_d_empty[g];
    assign w_dpush   = w_match & (~w_d_full | w_pop);
    assign w_drop[g] = w_match & w_d_full & ~w_pop;

    always_ff @(posedge i_clk) begin
      if (w_apush) r_amem[r_awp[AP_W-1:0]] <= i_ag_addr;
      if (w_dpush) r_dmem[r_dwp[DP_W-1:0]] <= i_data[w_lane*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
        r_awp  <= '0;
        r_arp  <= '0;
        r_dwp  <= '0;
        r_drp  <= '0;
        r_dout <= '0;
        r_vld  <= 1'b0;
      end else if (i_reg_clear) begin
        r_awp  <= '0;
        r_arp  <= '0;
        r_dwp  <= '0;
        r_drp  <= '0;
        r_dout <= '0;
        r_vld  <= 1'b0;
      end else begin
        // A match pops the address head even when its element is dropped.
        if (w_apush) r_awp <= r_awp + 1'b1;
        if (w_match) r_arp <= r_arp + 1'b1;
        if (w_dpush) r_dwp <= r_dwp + 1'b1;
        if (w_pop) begin
          r_drp  <= r_drp + 1'b1;
          r_dout <= r_dmem[r_drp[DP_W-1:0]];
        end
        r_vld <= w_pop;
      end
    end

    assign o_data[g*DATA_WIDTH +: DATA_WIDTH] = r_dout;
    assign o_data_valid[g]                    = r_vld;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_skew     <= '0;
      r_overflow <= 1'b0;
    end else if (i_reg_clear) begin
      r_skew     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (i_pop_en && (r_skew < SK_W'(ROUTER_COUNT - 1))) r_skew <= r_skew + 1'b1;
      if (|w_drop) r_overflow <= 1'b1;
    end
  end

  assign o_overflow   = r_overflow;
  assign o_addr_empty = &w_a_empty;
  assign o_data_empty = &w_d_empty;

endmodule

// File: tb/tb_skewed_row_dispatcher.sv
// tb/tb_skewed_row_dispatcher.sv - directed and random checks of skewed_row_dispatcher
// against a queue-based reference model.
module tb_skewed_row_dispatcher;

  logic        i_clk, i_nrst, i_reg_clear, i_skew_en, i_ag_valid, i_data_valid, i_pop_en;
  logic [1:0]  i_row_id;
  logic [10:0] i_ag_addr;
  logic [7:0]  i_addr;
  logic [63:0] i_data;
  logic        o_ag_ready, o_addr_empty, o_data_empty, o_overflow;
  logic [31:0] o_data;
  logic [3:0]  o_data_valid;

  skewed_row_dispatcher dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_reg_clear(i_reg_clear), .i_skew_en(i_skew_en),
    .i_ag_valid(i_ag_valid), .i_row_id(i_row_id), .i_ag_addr(i_ag_addr), .o_ag_ready(o_ag_ready),
    .i_data_valid(i_data_valid), .i_addr(i_addr), .i_data(i_data), .i_pop_en(i_pop_en),
    .o_data(o_data), .o_data_valid(o_data_valid), .o_addr_empty(o_addr_empty),
    .o_data_empty(o_data_empty), .o_overflow(o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_fail = 0;

  logic [10:0] aq [4][$];
  logic [7:0]  dq [4][$];
  logic [7:0]  ed [4];
  logic [3:0]  ev;
  logic        ovf;
  int          skew;
  int          first [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 4; r++) begin
      aq[r].delete();
      dq[r].delete();
      ed[r] = 8'h00;
    end
    ev = 4'h0;
    ovf = 1'b0;
    skew = 0;
  endtask

  task automatic check_outputs();
    bit ae, de;
    ae = 1;
    de = 1;
    for (int r = 0; r < 4; r++) begin
      if (aq[r].size() != 0) ae = 0;
      if (dq[r].size() != 0) de = 0;
      chk($sformatf("data_row%0d", r), 64'(o_data[r*8 +: 8]), 64'(ed[r]));
    end
    chk("data_valid", 64'(o_data_valid), 64'(ev));
    chk("overflow", 64'(o_overflow), 64'(ovf));
    chk("addr_empty", 64'(o_addr_empty), 64'(ae));
    chk("data_empty", 64'(o_data_empty), 64'(de));
  endtask

  // One clock: predict from the rules using the pre-edge inputs, then compare after the edge.
  task automatic tick();
    logic [3:0]  pop, mt;
    bit          acc, clr, pe;
    logic [63:0] d;
    logic [10:0] a, h;
    logic [1:0]  row;
    logic [7:0]  el;
    int          lane;
    chk("ag_ready", 64'(o_ag_ready), 64'(aq[i_row_id].size() < 16));
    for (int r = 0; r < 4; r++) begin
      pop[r] = i_pop_en && (!i_skew_en || skew >= r) && dq[r].size() > 0;
      mt[r]  = 1'b0;
      if (i_data_valid && aq[r].size() > 0) begin
        h = aq[r][0];
        mt[r] = (h[10:3] == i_addr);
      end
    end
    acc = i_ag_valid && aq[i_row_id].size() < 16;
    clr = i_reg_clear;
    pe  = i_pop_en;
    d   = i_data;
    a   = i_ag_addr;
    row = i_row_id;
    @(posedge i_clk);
    if (clr) begin
      model_clear();
    end else begin
      for (int r = 0; r < 4; r++) begin
        ev[r] = pop[r];
        if (pop[r]) ed[r] = dq[r].pop_front();
        if (mt[r]) begin
          h = aq[r].pop_front();
          lane = int'(h[2:0]);
          el = 8'(d >> (lane * 8));
          if (dq[r].size() < 16) dq[r].push_back(el);
          else ovf = 1'b1;
        end
      end
      if (acc) aq[row].push_back(a);
      if (pe && skew < 3) skew++;
    end
    #1;
    check_outputs();
  endtask

  task automatic push(input logic [1:0] row, input logic [10:0] addr);
    i_ag_valid = 1'b1;
    i_row_id = row;
    i_ag_addr = addr;
    tick();
    i_ag_valid = 1'b0;
  endtask

  task automatic beat(input logic [7:0] word, input logic [63:0] data);
    i_data_valid = 1'b1;
    i_addr = word;
    i_data = data;
    tick();
    i_data_valid = 1'b0;
  endtask

  task automatic reg_clear();
    i_reg_clear = 1'b1;
    tick();
    i_reg_clear = 1'b0;
  endtask

  task automatic preload3();
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 3; k++) push(2'(r), {8'(16 + k), 3'($urandom)});
    for (int k = 0; k < 3; k++) beat(8'(16 + k), {$urandom, $urandom});
  endtask

  task automatic measure_skew(input string tag);
    for (int r = 0; r < 4; r++) first[r] = -1;
    i_pop_en = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      for (int r = 0; r < 4; r++)
        if (o_data_valid[r] && first[r] < 0) first[r] = t;
    end
    i_pop_en = 1'b0;
    for (int r = 0; r < 4; r++) chk($sformatf("%s_first_row%0d", tag, r), 64'(first[r]), 64'(r + 1));
    chk({tag, "_drained"}, 64'(o_data_empty), 64'd1);
  endtask

  initial begin
    i_nrst = 1'b0; i_reg_clear = 1'b0; i_skew_en = 1'b0; i_ag_valid = 1'b0; i_row_id = 2'd0;
    i_ag_addr = '0; i_data_valid = 1'b0; i_addr = '0; i_data = '0; i_pop_en = 1'b0;
    model_clear();
    repeat (2) @(posedge i_clk);
    #1;
    check_outputs();
    chk("reset_ag_ready", 64'(o_ag_ready), 64'd1);
    @(negedge i_clk);
    i_nrst = 1'b1;

    // Lane extraction from a single beat.
    push(2'd2, 11'h013);
    beat(8'h02, 64'h8877665544332211);
    chk("addr_empty_after_match", 64'(o_addr_empty), 64'd1);
    i_pop_en = 1'b1;
    tick();
    i_pop_en = 1'b0;
    chk("row2_lane3", 64'(o_data[23:16]), 64'h44);

    // Staggered release.
    reg_clear();
    preload3();
    i_skew_en = 1'b1;
    measure_skew("skew");

    // Simultaneous release.
    reg_clear();
    preload3();
    i_skew_en = 1'b0;
    i_pop_en = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      chk($sformatf("noskew_valid_t%0d", t), 64'(o_data_valid), (t <= 3) ? 64'hF : 64'h0);
    end
    i_pop_en = 1'b0;

    // Address FIFO full boundary.
    reg_clear();
    for (int k = 0; k < 16; k++) push(2'd0, {8'h20, 3'(k)});
    i_row_id = 2'd0;
    #1;
    chk("addr_full_ready", 64'(o_ag_ready), 64'd0);
    push(2'd0, 11'h100);
    for (int k = 0; k < 16; k++) begin
      beat(8'h20, {$urandom, $urandom});
      if (k == 14) chk("addr_15_drained", 64'(o_addr_empty), 64'd0);
    end
    chk("addr_16_drained", 64'(o_addr_empty), 64'd1);

    // Full data FIFO popped in the same cycle still accepts the match.
    push(2'd0, 11'h10D);
    i_pop_en = 1'b1;
    beat(8'h21, {$urandom, $urandom});
    i_pop_en = 1'b0;
    chk("full_pop_accept_ovf", 64'(o_overflow), 64'd0);

    // Dropped match on a full data FIFO.
    reg_clear();
    for (int k = 0; k < 16; k++) push(2'd1, {8'h30, 3'(k)});
    for (int k = 0; k < 16; k++) beat(8'h30, {$urandom, $urandom});
    push(2'd1, 11'h182);
    beat(8'h30, 64'hDEADBEEF01234567);
    chk("drop_overflow", 64'(o_overflow), 64'd1);
    chk("drop_addr_popped", 64'(o_addr_empty), 64'd1);
    repeat (3) tick();
    chk("overflow_sticky", 64'(o_overflow), 64'd1);
    reg_clear();
    chk("overflow_cleared", 64'(o_overflow), 64'd0);

    // Asynchronous reset mid-stream, then skew restarts from row 0.
    preload3();
    i_skew_en = 1'b1;
    i_pop_en = 1'b1;
    tick();
    tick();
    #2;
    i_nrst = 1'b0;
    #1;
    model_clear();
    check_outputs();
    i_pop_en = 1'b0;
    @(negedge i_clk);
    i_nrst = 1'b1;
    preload3();
    measure_skew("post_reset");

    // Randomized traffic against the model.
    reg_clear();
    for (int c = 0; c < 500; c++) begin
      i_ag_valid   = 1'($urandom_range(0, 1));
      i_row_id     = 2'($urandom_range(0, 3));
      i_ag_addr    = {8'($urandom_range(0, 3)), 3'($urandom)};
      i_data_valid = ($urandom_range(0, 2) != 0);
      i_addr       = 8'($urandom_range(0, 3));
      i_data       = {$urandom, $urandom};
      i_pop_en     = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 31) == 0) i_skew_en = ~i_skew_en;
      i_reg_clear  = ($urandom_range(0, 149) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/skewed_row_dispatcher.md
# skewed_row_dispatcher

Parametrised successor to the four-lane row grouping in the input router. It accepts generated element addresses, one per cycle, and steers each into one of ROUTER_COUNT per-row address queues. It then captures matching byte lanes from SRAM read beats into per-row data FIFOs. Finally it releases the rows to the systolic array with an optional one-cycle-per-row skew. Compared with the previous block it adds configurable queue depths, a ready/backpressure path on address push, a bypassable skew, and overflow reporting.

## Interface
- ROUTER_COUNT, 4: number of row channels (≥2)
- SRAM_DATA_WIDTH, 64: SRAM beat width
- DATA_WIDTH, 8: element width. LANES = SRAM_DATA_WIDTH/DATA_WIDTH (power of 2). LANE_BITS = log2(LANES).
- ADDR_WIDTH, 11: element address width. Upper ADDR_WIDTH-LANE_BITS bits form the word address; the low LANE_BITS bits form the lane.
- ADDR_DEPTH, 16: per-row address FIFO depth (power of 2)
- DATA_DEPTH, 16: per-row data FIFO depth (power of 2)

Ports:
- i_clk  in  1  clock. One clock domain; all logic is rising-edge.
- i_nrst  in  1  reset. Asynchronous, active-low.
- i_reg_clear  in  1  synchronous clear of all state; highest priority after reset
- i_skew_en  in  1  1 = staggered row release, 0 = all rows release together
- i_ag_valid  in  1  address push request
- i_row_id  in  clog2(ROUTER_COUNT)  target row of the push
- i_ag_addr  in  ADDR_WIDTH  element address being pushed
- o_ag_ready  out  1  combinational. High when the addr FIFO of row i_row_id is not full.
- i_data_valid  in  1  SRAM beat valid
- i_addr  in  ADDR_WIDTH-LANE_BITS  word address of the beat
- i_data  in  SRAM_DATA_WIDTH  beat data. Lane k = bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_pop_en  in  1  level request to stream rows out
- o_data  out  ROUTER_COUNT×DATA_WIDTH  per-row output element, registered
- o_data_valid  out  ROUTER_COUNT  per-row output valid, registered
- o_addr_empty  out  1  all addr FIFOs empty
- o_data_empty  out  1  all data FIFOs empty
- o_overflow  out  1  sticky. Set when a match was dropped because the data FIFO was full.

## Operation
- Push: the push is accepted when i_ag_valid & o_ag_ready. i_ag_addr is written to the tail of addr FIFO[i_row_id]. An i_row_id ≥ ROUTER_COUNT is ignored and o_ag_ready reads 0 for it.
- Match is evaluated per row, in parallel, on each i_data_valid cycle.
  - Row r matches when its addr FIFO is non-empty and the head word address equals i_addr.
  - On a match, lane = head[LANE_BITS-1:0]. That lane of i_data is pushed into data FIFO[r] and the addr head is popped.
  - Only the head is compared, so at most one element per row per beat.
- Dropped match: if data FIFO[r] is full and is not popped in the same cycle, the match is dropped. The addr head is still popped and o_overflow is set. The tile reader must not overrun.
- Skew counter: clog2(ROUTER_COUNT)+1 bits, reset 0. It increments on each cycle with i_pop_en high and saturates at ROUTER_COUNT-1. It holds while i_pop_en is low and is cleared only by reset or i_reg_clear.
- Row enable: row r is enabled when i_skew_en=0, or when skew_cnt ≥ r, with skew_cnt compared before the increment.
- Pop: in a cycle where i_pop_en & enabled[r] & data FIFO[r] non-empty, the head is popped. On the next edge o_data[r] is loaded with the head and o_data_valid[r] is set to 1.
- Otherwise o_data_valid[r] is 0 and o_data[r] holds its last value.
- No bypass: an element pushed into an empty FIFO at edge T is poppable from cycle T+1 onward. Likewise, an address pushed at edge T is matchable from T+1 onward.
- Reset (async, any time) and i_reg_clear have the same effect: all FIFO pointers, skew_cnt, o_data, o_data_valid and o_overflow go to 0. In-flight data is discarded.

## Timing
- Reset values: o_data=0, o_data_valid=0, o_overflow=0, o_addr_empty=1, o_data_empty=1. o_ag_ready=1 for a valid i_row_id.
- o_addr_empty, o_data_empty and o_ag_ready are combinational from registered FIFO state.
- Push to match eligibility: 1 cycle.
- Match to pop eligibility: 1 cycle.
- Pop to o_data_valid: 1 cycle.
- Skewed start: i_pop_en rises in cycle T. Row r first pops in cycle T+r, giving o_data_valid[r] at T+r+1 if that row has data.
- Full/empty boundaries:
  - A push to a full addr FIFO is blocked (o_ag_ready=0).
  - A data FIFO that is full but popped in the same cycle accepts a match.
  - Pointers wrap modulo depth, with an extra MSB to distinguish full from empty.

## Test plan
- Reset, then push addr 0x013 to row 2, then send a beat at i_addr=0x02 with i_data=0x8877665544332211. Required: data FIFO[2] holds 0x44; o_addr_empty returns to 1.
- i_skew_en=1 with 3 elements preloaded in each of 4 rows, and i_pop_en held high from cycle T. Required: o_data_valid[r] first asserts at T+r+1. Each row streams 3 consecutive elements, then o_data_empty=1.
- i_skew_en=0, same preload. Required: all o_data_valid bits assert together at T+1 for 3 cycles.
- Fill row 0's addr FIFO to 16 entries. Required: o_ag_ready=0; a 17th push leaves the count at 16.
- Fill data FIFO[1] to 16 entries, then send a matching beat with no pop. Required: element dropped, addr head popped, o_overflow=1 and sticky until i_reg_clear.
- Assert i_nrst low mid-stream, asynchronously between edges. Required: o_data_valid=0 immediately, o_addr_empty=o_data_empty=1. After release, a restart of i_pop_en begins the skew from row 0.
